// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter: FSM states, frame word
// layout and the command bytes understood by the companion receiver.
package debug_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } dump_state_e;

  // Frame layout: PC, CYCLES, register file, then data memory
  localparam int unsigned WORD_PC   = 0;
  localparam int unsigned WORD_CYC  = 1;
  localparam int unsigned WORD_REG0 = 2;

  function automatic int unsigned word_mem0(input int unsigned n_regs);
    return WORD_REG0 + n_regs;
  endfunction

  localparam logic [7:0] CMD_START        = 8'h01;
  localparam logic [7:0] CMD_CONTINUOUS   = 8'h02;
  localparam logic [7:0] CMD_STEP_BY_STEP = 8'h03;
  localparam logic [7:0] CMD_STEP         = 8'h05;
  localparam logic [7:0] CMD_REPROGRAM    = 8'h06;

endpackage

// File: rtl/debug_dump_tx_word_shifter.sv
// Holds one dump word and presents it a byte at a time, LSB first; the byte
// counter saturates on the last byte so extra shift requests are harmless.
module debug_dump_tx_word_shifter #(
  parameter int unsigned LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [LEN-1:0] word,
  input  logic           shift,
  output logic [7:0]     tx_byte,
  output logic           last_c
);

  localparam int unsigned N_BYTES = LEN / 8;
  localparam int unsigned NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);

  logic [LEN-1:0]     sh;
  logic [NB_BIDX-1:0] byte_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      byte_idx <= '0;
    end else if (load) begin
      sh       <= word;
      byte_idx <= '0;
    end else if (shift && !last_c) begin
      sh       <= sh >> 8;
      byte_idx <= byte_idx + NB_BIDX'(1);
    end
  end

  assign tx_byte = sh[7:0];
  assign last_c  = (byte_idx == LAST_BYTE);

endmodule

// File: rtl/debug_dump_tx.sv
// Serialises PC, cycle count, register file and data memory to the UART
// transmitter, one byte per start/done handshake.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int unsigned LEN         = 32,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned N_MEM_WORDS = 16,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_MEM_ADDR = 10
) (
  input  logic                   CLK100MHZ,
  input  logic                   SWITCH_RESET,
  input  logic                   i_send,
  input  logic [LEN-1:0]         i_pc,
  input  logic [LEN-1:0]         i_cycles,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [LEN-1:0]         i_reg_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  input  logic [LEN-1:0]         i_mem_data,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned N_WORDS = WORD_REG0 + N_REGS + N_MEM_WORDS;
  localparam int unsigned MEM0    = word_mem0(N_REGS);
  localparam int unsigned NB_WIDX = $clog2(N_WORDS);
  localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(N_WORDS - 1);

  dump_state_e        state;
  logic [NB_WIDX-1:0] word_idx;
  logic [NB_WIDX-1:0] next_word_c;
  logic [LEN-1:0]     pc_snap;
  logic [LEN-1:0]     cyc_snap;
  logic [LEN-1:0]     word_c;
  logic               reg_sel_c;
  logic               mem_sel_c;
  logic               last_byte_c;
  logic               load_c;
  logic               shift_c;

  // Word source for LATCH and address target for the following word
  always_comb begin
    next_word_c = word_idx + NB_WIDX'(1);
    reg_sel_c   = (next_word_c >= NB_WIDX'(WORD_REG0)) && (next_word_c < NB_WIDX'(MEM0));
    mem_sel_c   = (next_word_c >= NB_WIDX'(MEM0));
    if (word_idx == NB_WIDX'(WORD_PC))     word_c = pc_snap;
    else if (word_idx == NB_WIDX'(WORD_CYC)) word_c = cyc_snap;
    else if (word_idx < NB_WIDX'(MEM0))      word_c = i_reg_data;
    else                                     word_c = i_mem_data;
  end

  assign load_c  = (state == ST_LATCH);
  assign shift_c = (state == ST_WAIT) && i_tx_done;

  debug_dump_tx_word_shifter #(.LEN(LEN)) u_shifter (
    .clk     (CLK100MHZ),
    .rst     (SWITCH_RESET),
    .load    (load_c),
    .word    (word_c),
    .shift   (shift_c),
    .tx_byte (o_tx_data),
    .last_c  (last_byte_c)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (SWITCH_RESET) begin
      state      <= ST_IDLE;
      word_idx   <= '0;
      pc_snap    <= '0;
      cyc_snap   <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_send) begin
            pc_snap  <= i_pc;
            cyc_snap <= i_cycles;
            word_idx <= '0;
            o_busy   <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD:  state <= ST_LATCH;
        ST_LATCH: begin
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND:  state <= ST_WAIT;
        ST_WAIT: begin
          if (i_tx_done) begin
            if (!last_byte_c) begin
              o_tx_start <= 1'b1;
              state      <= ST_SEND;
            end else if (word_idx != LAST_WORD) begin
              word_idx <= next_word_c;
              if (reg_sel_c) o_reg_addr <= NB_REG_ADDR'(next_word_c - NB_WIDX'(WORD_REG0));
              if (mem_sel_c) o_mem_addr <= NB_MEM_ADDR'(next_word_c - NB_WIDX'(MEM0));
              state <= ST_LOAD;
            end else begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected byte frames are queued when a
// dump is requested and a monitor pops them on every transmit strobe.
module tb_debug_dump_tx;

  localparam int unsigned LEN         = 32;
  localparam int unsigned N_REGS      = 32;
  localparam int unsigned N_MEM       = 16;
  localparam int unsigned BPW         = LEN / 8;
  localparam int unsigned TOTAL_BYTES = (2 + N_REGS + N_MEM) * BPW;

  logic        clk;
  logic        rst;
  logic        i_send;
  logic [31:0] i_pc, i_cycles;
  logic [4:0]  o_reg_addr;
  logic [9:0]  o_mem_addr;
  logic [31:0] reg_data, mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_busy, o_done;
  logic        tx_done, uart_done, inject_send, inject_idle;

  logic [31:0] regs [N_REGS];
  logic [31:0] mems [N_MEM];
  logic [7:0]  exp_q [$];

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int uart_cnt;
  bit uart_rand = 1'b0;

  debug_dump_tx dut (
    .CLK100MHZ    (clk),
    .SWITCH_RESET (rst),
    .i_send       (i_send),
    .i_pc         (i_pc),
    .i_cycles     (i_cycles),
    .o_reg_addr   (o_reg_addr),
    .i_reg_data   (reg_data),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (mem_data),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (tx_done),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_done = uart_done | (inject_send & o_tx_start) | inject_idle;

  // UART transmitter model: done strobe a few cycles after each start
  always @(posedge clk) begin
    if (rst) begin
      uart_cnt  <= 0;
      uart_done <= 1'b0;
    end else begin
      uart_done <= 1'b0;
      if (o_tx_start) uart_cnt <= uart_rand ? int'($urandom_range(5, 1)) : 3;
      else if (uart_cnt > 0) begin
        uart_cnt <= uart_cnt - 1;
        if (uart_cnt == 1) uart_done <= 1'b1;
      end
    end
  end

  // Register file and data memory with one-cycle read latency
  always @(posedge clk) begin
    reg_data <= regs[o_reg_addr];
    mem_data <= (o_mem_addr < 10'(N_MEM)) ? mems[o_mem_addr[3:0]] : 32'hDEAD_BEEF;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: consumes expected bytes on each strobe, checks hold and done timing
  initial begin : monitor
    logic       prev_done;
    logic       in_flight;
    logic [7:0] last_byte;
    logic [7:0] e;
    prev_done = 1'b0;
    in_flight = 1'b0;
    last_byte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (o_tx_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got byte %h, expected no strobe (t=%0t)", o_tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(o_tx_data), 32'(e));
          end
          in_flight = 1'b1;
          last_byte = o_tx_data;
        end else if (tx_done && in_flight) begin
          check("tx_data_hold", 32'(o_tx_data), 32'(last_byte));
          in_flight = 1'b0;
        end
        if (o_done) begin
          done_cnt++;
          check("done_after_last_tx_done", 32'(prev_done), 32'd1);
          check("done_queue_drained", 32'(exp_q.size()), 32'd0);
          check("busy_low_in_done", 32'(o_busy), 32'd0);
        end
        prev_done = tx_done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    logic [31:0] words [$];
    logic [31:0] w;
    words.push_back(pc);
    words.push_back(cyc);
    for (int k = 0; k < int'(N_REGS); k++) words.push_back(regs[k]);
    for (int k = 0; k < int'(N_MEM); k++) words.push_back(mems[k]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < int'(BPW); b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic start_dump(input logic [31:0] pc, input logic [31:0] cyc);
    i_pc     = pc;
    i_cycles = cyc;
    i_send   = 1'b1;
    push_dump(pc, cyc);
    tick();
    i_send   = 1'b0;
    i_pc     = $urandom;
    i_cycles = $urandom;
    check("busy_after_accept", 32'(o_busy), 32'd1);
    tick();
    check("no_start_before_latency", 32'(o_tx_start), 32'd0);
    tick();
    check("first_start_latency", 32'(o_tx_start), 32'd1);
    check("first_byte_pc_lsb", 32'(o_tx_data), 32'(pc[7:0]));
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_starts_reached", 32'(start_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(o_done), 32'd1);
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = 32'(k) * 32'h0101_0101;
    for (int k = 0; k < int'(N_MEM); k++) mems[k] = 32'hA000_0000 + 32'(k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < int'(N_REGS); k++) regs[k] = $urandom;
    for (int k = 0; k < int'(N_MEM); k++) mems[k] = $urandom;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int bs, bd;
    rst         = 1'b1;
    i_send      = 1'b0;
    i_pc        = '0;
    i_cycles    = '0;
    inject_send = 1'b0;
    inject_idle = 1'b0;
    fill_pattern();

    // Reset state and quiet period
    repeat (3) tick();
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_reg_addr", 32'(o_reg_addr), 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    rst = 1'b0;
    bs = start_cnt;
    repeat (50) tick();
    check("quiet_after_reset", 32'(start_cnt), 32'(bs));

    // Directed dump with patterned register/memory contents
    bs = start_cnt; bd = done_cnt;
    start_dump(32'h0000_0010, 32'h0000_0007);
    wait_done(5000);
    tick();
    check("dump_bytes_directed", 32'(start_cnt - bs), 32'(TOTAL_BYTES));
    check("dump_dones_directed", 32'(done_cnt - bd), 32'd1);

    // Requests while busy and in the DONE cycle are dropped
    uart_rand = 1'b1;
    bs = start_cnt; bd = done_cnt;
    start_dump($urandom, $urandom);
    wait_starts(bs + 6, 1000);
    i_send = 1'b1; tick(); i_send = 1'b0;
    wait_starts(bs + int'(TOTAL_BYTES), 5000);
    i_send = 1'b1; tick(); i_send = 1'b0;
    wait_done(100);
    i_send = 1'b1; tick(); i_send = 1'b0;
    repeat (20) tick();
    check("ignored_send_bytes", 32'(start_cnt - bs), 32'(TOTAL_BYTES));
    check("ignored_send_dones", 32'(done_cnt - bd), 32'd1);
    check("ignored_send_idle", 32'(o_busy), 32'd0);

    // Reset mid-dump aborts; reset beats a simultaneous request
    fill_random();
    bs = start_cnt;
    start_dump($urandom, $urandom);
    wait_starts(bs + 38, 1000);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_tx_start", 32'(o_tx_start), 32'd0);
    rst = 1'b0;
    bs = start_cnt;
    repeat (50) tick();
    check("quiet_after_abort", 32'(start_cnt), 32'(bs));
    rst = 1'b1; i_send = 1'b1;
    tick();
    rst = 1'b0; i_send = 1'b0;
    repeat (10) tick();
    check("reset_wins_busy", 32'(o_busy), 32'd0);
    check("reset_wins_quiet", 32'(start_cnt), 32'(bs));
    bs = start_cnt; bd = done_cnt;
    start_dump($urandom, $urandom);
    wait_done(5000);
    tick();
    check("restart_bytes", 32'(start_cnt - bs), 32'(TOTAL_BYTES));
    check("restart_dones", 32'(done_cnt - bd), 32'd1);

    // Stray done strobes in IDLE and during SEND cycles
    inject_idle = 1'b1;
    repeat (5) tick();
    inject_idle = 1'b0;
    inject_send = 1'b1;
    bs = start_cnt; bd = done_cnt;
    start_dump($urandom, $urandom);
    wait_done(5000);
    inject_send = 1'b0;
    tick();
    check("stray_done_bytes", 32'(start_cnt - bs), 32'(TOTAL_BYTES));
    check("stray_done_dones", 32'(done_cnt - bd), 32'd1);

    // Randomised dumps
    for (int r = 0; r < 3; r++) begin
      fill_random();
      repeat ($urandom_range(8, 1)) tick();
      bs = start_cnt; bd = done_cnt;
      start_dump($urandom, $urandom);
      wait_done(5000);
      tick();
      check("rand_bytes", 32'(start_cnt - bs), 32'(TOTAL_BYTES));
      check("rand_dones", 32'(done_cnt - bd), 32'd1);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
